writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 178 +++++++++++++++++
 tb/tb_writeback_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage
//   Y86-64 pipeline write-back stage. It holds the W pipeline register,
//   decodes the register-file write addresses and enables, tracks the sticky
//   halt status, and counts retired instructions.
//
//   Optional feature macro: WB_FORWARD_EN. When it is defined, the module
//   gains combinational W-to-decode forwarding ports.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   m_valid .. m_valM   memory-stage instruction fields, captured into W
//   w_stall, w_bubble   W register hold / nop-injection controls (stall wins)
//   dstE, dstM          register-file write addresses (4'hF = none)
//   valE, valM          register-file write data, taken straight from W
//   weE, weM            register-file write enables
//   halted              sticky halt/error status, cleared only by rst
//   retired_cnt         wrapping count of retired valid instructions
//   (WB_FORWARD_EN) d_srcA/B in; fwdA/B_hit and fwdA/B_val out
// ----------------------------------------------------------------------------
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [3:0]  m_icode,
    input  logic        m_cnd,
    input  logic [3:0]  m_rA,
    input  logic [3:0]  m_rB,
    input  logic [63:0] m_valE,
    input  logic [63:0] m_valM,
    input  logic        w_stall,
    input  logic        w_bubble,
`ifdef WB_FORWARD_EN
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic        fwdA_hit,
    output logic        fwdB_hit,
    output logic [63:0] fwdA_val,
    output logic [63:0] fwdB_val,
`endif
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valE,
    output logic [63:0] valM,
    output logic        weE,
    output logic        weM,
    output logic        halted,
    output logic [31:0] retired_cnt
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] I_NOP    = 4'h1;

    // W pipeline register
    logic        w_valid_reg;
    logic [3:0]  w_icode_reg;
    logic        w_cnd_reg;
    logic [3:0]  w_rA_reg;
    logic [3:0]  w_rB_reg;
    logic [63:0] w_valE_reg;
    logic [63:0] w_valM_reg;

    logic        halted_reg;
    logic [31:0] retired_cnt_reg;

    logic [3:0]  dst_e_next;
    logic [3:0]  dst_m_next;
    logic        we_e_next;
    logic        we_m_next;
    logic        w_is_halt;

    // halt and the invalid icodes C-F both stop the machine
    assign w_is_halt = (w_icode_reg == 4'h0) || (w_icode_reg >= 4'hC);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid_reg     <= 1'b0;
            w_icode_reg     <= I_NOP;
            w_cnd_reg       <= 1'b0;
            w_rA_reg        <= REG_NONE;
            w_rB_reg        <= REG_NONE;
            w_valE_reg      <= 64'd0;
            w_valM_reg      <= 64'd0;
            halted_reg      <= 1'b0;
            retired_cnt_reg <= 32'd0;
        end else begin
            if (!w_stall) begin
                if (w_bubble) begin
                    w_valid_reg <= 1'b0;
                    w_icode_reg <= I_NOP;
                    w_cnd_reg   <= 1'b0;
                    w_rA_reg    <= REG_NONE;
                    w_rB_reg    <= REG_NONE;
                    w_valE_reg  <= 64'd0;
                    w_valM_reg  <= 64'd0;
                end else begin
                    w_valid_reg <= m_valid;
                    w_icode_reg <= m_icode;
                    w_cnd_reg   <= m_cnd;
                    w_rA_reg    <= m_rA;
                    w_rB_reg    <= m_rB;
                    w_valE_reg  <= m_valE;
                    w_valM_reg  <= m_valM;
                end
            end

            // an instruction retires when it leaves W while the machine runs
            if (w_valid_reg && !halted_reg && !w_stall) begin
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
            end

            if (w_valid_reg && w_is_halt) begin
                halted_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        dst_e_next = REG_NONE;
        dst_m_next = REG_NONE;
        case (w_icode_reg)
            4'h2:       dst_e_next = w_cnd_reg ? w_rB_reg : REG_NONE;
            4'h3, 4'h6: dst_e_next = w_rB_reg;
            4'h5:       dst_m_next = w_rA_reg;
            4'h8, 4'h9, 4'hA: dst_e_next = REG_RSP;
            4'hB: begin
                dst_e_next = REG_RSP;
                dst_m_next = w_rA_reg;
            end
            default: begin
                dst_e_next = REG_NONE;
                dst_m_next = REG_NONE;
            end
        endcase
    end

    // popq %rsp makes dstE==dstM; only the loaded value may reach the register
    assign we_m_next = w_valid_reg && !halted_reg && (dst_m_next != REG_NONE);
    assign we_e_next = w_valid_reg && !halted_reg && (dst_e_next != REG_NONE)
                       && !((dst_e_next == dst_m_next) && we_m_next);

    assign dstE        = dst_e_next;
    assign dstM        = dst_m_next;
    assign valE        = w_valE_reg;
    assign valM        = w_valM_reg;
    assign weE         = we_e_next;
    assign weM         = we_m_next;
    assign halted      = halted_reg;
    assign retired_cnt = retired_cnt_reg;

`ifdef WB_FORWARD_EN
    logic [3:0]  fwd_src [2];
    logic        fwd_hit [2];
    logic [63:0] fwd_val [2];

    assign fwd_src[0] = d_srcA;
    assign fwd_src[1] = d_srcB;

    // the M write has priority, matching the register-file outcome
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_m;
            logic hit_e;
            assign hit_m = we_m_next && (fwd_src[gi] == dst_m_next);
            assign hit_e = we_e_next && (fwd_src[gi] == dst_e_next);
            assign fwd_hit[gi] = (fwd_src[gi] != REG_NONE) && (hit_m || hit_e);
            assign fwd_val[gi] = hit_m ? w_valM_reg : w_valE_reg;
        end
    endgenerate

    assign fwdA_hit = fwd_hit[0];
    assign fwdB_hit = fwd_hit[1];
    assign fwdA_val = fwd_val[0];
    assign fwdB_val = fwd_val[1];
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ----------------------------------------------------------------------------
// tb_writeback_stage
//   Self-checking bench for writeback_stage: directed scenarios followed by
//   randomized traffic, compared against a behavioural model of the W slot,
//   halt flag and retirement counter. Forwarding checks are compiled in when
//   WB_FORWARD_EN is defined.
// ----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, m_valid, m_cnd, w_stall, w_bubble;
    logic [3:0]  m_icode, m_rA, m_rB;
    logic [63:0] m_valE, m_valM;
    logic [3:0]  dstE, dstM;
    logic [63:0] valE, valM;
    logic        weE, weM, halted;
    logic [31:0] retired_cnt;
`ifdef WB_FORWARD_EN
    logic [3:0]  d_srcA = 4'hF, d_srcB = 4'hF;
    logic        fwdA_hit, fwdB_hit;
    logic [63:0] fwdA_val, fwdB_val;
`endif

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_icode(m_icode),
        .m_cnd(m_cnd), .m_rA(m_rA), .m_rB(m_rB), .m_valE(m_valE),
        .m_valM(m_valM), .w_stall(w_stall), .w_bubble(w_bubble),
`ifdef WB_FORWARD_EN
        .d_srcA(d_srcA), .d_srcB(d_srcB), .fwdA_hit(fwdA_hit),
        .fwdB_hit(fwdB_hit), .fwdA_val(fwdA_val), .fwdB_val(fwdB_val),
`endif
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM), .weE(weE),
        .weM(weM), .halted(halted), .retired_cnt(retired_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // The W slot is modelled as a plain instruction record.
    typedef struct {
        logic        valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  rA, rB;
        logic [63:0] vE, vM;
    } instr_t;

    instr_t      mw;
    logic        m_halted;
    logic [31:0] m_count;

    function automatic instr_t nop_instr();
        instr_t t;
        t.valid = 1'b0; t.icode = 4'h1; t.cnd = 1'b0;
        t.rA = 4'hF; t.rB = 4'hF; t.vE = 64'd0; t.vM = 64'd0;
        return t;
    endfunction

    // register an instruction wants written through the E and M ports
    function automatic logic [3:0] want_e(input instr_t t);
        case (t.icode)
            4'h2: return t.cnd ? t.rB : 4'hF;
            4'h3, 4'h6: return t.rB;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] want_m(input instr_t t);
        if (t.icode == 4'h5 || t.icode == 4'hB) return t.rA;
        return 4'hF;
    endfunction

    function automatic logic runs(input instr_t t);
        return t.valid && !m_halted;
    endfunction

    function automatic logic exp_we_m();
        return runs(mw) && want_m(mw) != 4'hF;
    endfunction

    function automatic logic exp_we_e();
        // a register loaded through M is never also written from E
        if (!runs(mw) || want_e(mw) == 4'hF) return 1'b0;
        if (exp_we_m() && want_e(mw) == want_m(mw)) return 1'b0;
        return 1'b1;
    endfunction

    int step_no = 0;

    task automatic step(input logic r, input logic v, input logic [3:0] ic,
                        input logic c, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic st, input logic bb);
        instr_t nxt;
        rst = r; m_valid = v; m_icode = ic; m_cnd = c; m_rA = ra; m_rB = rb;
        m_valE = ve; m_valM = vm; w_stall = st; w_bubble = bb;
        nxt.valid = v; nxt.icode = ic; nxt.cnd = c; nxt.rA = ra; nxt.rB = rb;
        nxt.vE = ve; nxt.vM = vm;
        // model advance for the coming edge
        if (r) begin
            mw = nop_instr(); m_halted = 1'b0; m_count = 0;
        end else begin
            if (mw.valid && !m_halted && !st) m_count = m_count + 1;
            if (mw.valid && (mw.icode == 4'h0 || mw.icode >= 4'hC)) m_halted = 1'b1;
            if (!st) mw = bb ? nop_instr() : nxt;
        end
        @(posedge clk);
        @(negedge clk);
        step_no++;
        $display("step %0d: rst=%0b st=%0b bb=%0b icode=%0h -> dstE=%0h dstM=%0h weE=%0b weM=%0b halted=%0b cnt=%0d",
                 step_no, r, st, bb, ic, dstE, dstM, weE, weM, halted, retired_cnt);
        check("dstE", 64'(dstE), 64'(want_e(mw)));
        check("dstM", 64'(dstM), 64'(want_m(mw)));
        check("valE", valE, mw.vE);
        check("valM", valM, mw.vM);
        check("weE", 64'(weE), 64'(exp_we_e()));
        check("weM", 64'(weM), 64'(exp_we_m()));
        check("halted", 64'(halted), 64'(m_halted));
        check("retired_cnt", 64'(retired_cnt), 64'(m_count));
`ifdef WB_FORWARD_EN
        check_fwd();
`endif
    endtask

`ifdef WB_FORWARD_EN
    task automatic check_fwd();
        logic hA, hB;
        logic [63:0] vA, vB;
        hA = 1'b0; vA = mw.vE; hB = 1'b0; vB = mw.vE;
        if (d_srcA != 4'hF) begin
            if (exp_we_m() && d_srcA == want_m(mw)) begin hA = 1'b1; vA = mw.vM; end
            else if (exp_we_e() && d_srcA == want_e(mw)) hA = 1'b1;
        end
        if (d_srcB != 4'hF) begin
            if (exp_we_m() && d_srcB == want_m(mw)) begin hB = 1'b1; vB = mw.vM; end
            else if (exp_we_e() && d_srcB == want_e(mw)) hB = 1'b1;
        end
        check("fwdA_hit", 64'(fwdA_hit), 64'(hA));
        check("fwdB_hit", 64'(fwdB_hit), 64'(hB));
        if (hA) check("fwdA_val", fwdA_val, vA);
        if (hB) check("fwdB_val", fwdB_val, vB);
    endtask
`endif

    initial begin
        mw = nop_instr(); m_halted = 1'b0; m_count = 0;
        rst = 1'b1; m_valid = 0; m_icode = 0; m_cnd = 0; m_rA = 4'hF; m_rB = 4'hF;
        m_valE = 0; m_valM = 0; w_stall = 0; w_bubble = 0;
        @(negedge clk);

        // reset overrides stall/bubble; explicit reset-state checks
        step(1, 1, 4'h6, 0, 4'h1, 4'h2, 64'h5, 64'h6, 1, 1);
        check("rst_dstE", 64'(dstE), 64'hF);
        check("rst_valE", valE, 64'd0);
        check("rst_cnt", 64'(retired_cnt), 64'd0);

        // OPq into %rbx
        step(0, 1, 4'h6, 0, 4'hF, 4'h3, 64'h10, 64'h0, 0, 0);
        check("opq_dstE", 64'(dstE), 64'h3);
        check("opq_weE", 64'(weE), 64'h1);
        // cmov not taken, OPq retires on this edge
        step(0, 1, 4'h2, 0, 4'h1, 4'h5, 64'h22, 64'h0, 0, 0);
        check("opq_cnt", 64'(retired_cnt), 64'd1);
        check("cmov_weE", 64'(weE), 64'h0);
        // popq %rsp
        step(0, 1, 4'hB, 0, 4'h4, 4'hF, 64'h100, 64'hAA, 0, 0);
        check("cmov_cnt", 64'(retired_cnt), 64'd2);
        check("pop_weM", 64'(weM), 64'h1);
        check("pop_valM", valM, 64'hAA);
        check("pop_weE", 64'(weE), 64'h0);
`ifdef WB_FORWARD_EN
        // popq %rcx with forwarding probes
        d_srcA = 4'h1; d_srcB = 4'h4;
        step(0, 1, 4'hB, 0, 4'h1, 4'hF, 64'h200, 64'hBB, 0, 0);
        check("fwdA_hit_dir", 64'(fwdA_hit), 64'h1);
        check("fwdA_val_dir", fwdA_val, 64'hBB);
        check("fwdB_hit_dir", 64'(fwdB_hit), 64'h1);
        check("fwdB_val_dir", fwdB_val, 64'h200);
        d_srcA = 4'hF; d_srcB = 4'hF;
`endif
        // halt, then irmovq to %rdx must not write
        step(0, 1, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 0, 0);
        step(0, 1, 4'h3, 0, 4'hF, 4'h2, 64'h77, 64'h0, 0, 0);
        check("halt_set", 64'(halted), 64'h1);
        check("halt_weE", 64'(weE), 64'h0);
        step(0, 1, 4'h6, 0, 4'hF, 4'h1, 64'h1, 64'h0, 0, 0);
        step(1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0, 64'h0, 0, 0);
        check("halt_clear", 64'(halted), 64'h0);
        check("halt_cnt0", 64'(retired_cnt), 64'd0);

        // mrmovq into %rdi, then stall+bubble for three cycles
        step(0, 1, 4'h5, 0, 4'h7, 4'h2, 64'h40, 64'h99, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'h6, 0, 4'h1, 4'h1, 64'h1, 64'h2, 1, 1);
            check("stall_weM", 64'(weM), 64'h1);
            check("stall_cnt", 64'(retired_cnt), 64'd0);
        end
        step(0, 1, 4'h6, 0, 4'h1, 4'h1, 64'h1, 64'h2, 0, 1);
        check("bub_weM", 64'(weM), 64'h0);
        check("bub_cnt", 64'(retired_cnt), 64'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic r, v, c, st, bb;
            logic [3:0] ic, ra, rb;
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) != 0);
            ic = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(1, 11));
            c  = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 4'h4 : 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 4) == 0);
            bb = ($urandom_range(0, 6) == 0);
`ifdef WB_FORWARD_EN
            d_srcA = 4'($urandom_range(0, 15));
            d_srcB = ($urandom_range(0, 2) == 0) ? 4'h4 : 4'($urandom_range(0, 15));
`endif
            step(r, v, ic, c, ra, rb, {$urandom, $urandom}, {$urandom, $urandom}, st, bb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
